// File: rtl/clk_div_multi.sv
// clk_div_multi -- NCH independent programmable clock dividers on clk50.
//
// Each channel counts 0..div while it runs. The cycle where the count wraps
// toggles clk_out on the next edge, so the clk_out period is 2*(div+1)
// cycles. A one-cycle pulse strobe fires on the edge after count == pulse_off,
// but only when pulse_off < div. The wrap wins over the pulse.
// In one-shot mode a channel runs a single 0..div count after each rising
// edge of en, then stays idle until en falls and rises again.
//
// Config handshake: a transfer happens on a rising clk50 edge where
// cfg_valid && cfg_ready. cfg_ready is combinational and equals the inverse
// of the target channel's pending flag. It is forced high for valid channels
// while rst_n is low, and it is forced low for cfg_ch >= NCH. The master must
// hold cfg_ch/cfg_div/cfg_pulse/cfg_mode stable while cfg_valid is high.
// An accepted config goes into a shadow set. The shadow set moves to the
// active set at the channel's next wrap, or on the next edge if the channel
// is not busy, so a period is never cut short or stretched mid-count.
//
// Ports:
//   clk50      in   single clock; all logic is on its rising edge
//   rst_n      in   synchronous active-low reset
//   en         in   per-channel run enable [NCH]
//   cfg_valid  in   config request
//   cfg_ready  out  config can be accepted (combinational)
//   cfg_ch     in   target channel
//   cfg_div    in   new divide value [CNT_W]
//   cfg_pulse  in   new pulse offset [CNT_W]
//   cfg_mode   in   0 = continuous, 1 = one-shot
//   clk_out    out  divided clocks, registered [NCH]
//   pulse      out  one-cycle strobes, registered [NCH]
//   busy       out  channel counting, registered [NCH]
module clk_div_multi #(
  parameter int NCH       = 4,
  parameter int CNT_W     = 24,
  parameter int DEF_DIV   = 12_500_000,
  parameter int DEF_PULSE = 12_400_000,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk50,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_pulse,
  input  logic             cfg_mode,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   pulse,
  output logic [NCH-1:0]   busy
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] POFF_RST = CNT_W'(DEF_PULSE);

  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][CNT_W-1:0] div_q, div_d, poff_q, poff_d;
  logic [NCH-1:0][CNT_W-1:0] sdiv_q, sdiv_d, spoff_q, spoff_d;
  logic [NCH-1:0] mode_q, mode_d, smode_q, smode_d, pend_q, pend_d;
  logic [NCH-1:0] clk_q, clk_d, pulse_q, pulse_d, busy_q, busy_d, en_q, en_d;

  logic [NCH-1:0] running, wrap, rise;
  logic           xfer;

  // A channel advances only while it is already busy and still enabled.
  // The cycle en rises loads count 0, and counting starts on the next edge.
  assign running = busy_q & en;
  assign rise    = en & ~en_q;
  assign en_d    = en;

  for (genvar g = 0; g < NCH; g++) begin : g_wrap
    assign wrap[g] = running[g] & (cnt_q[g] == div_q[g]);
  end

  // Scan the channels instead of indexing pending directly, so an out-of-range
  // cfg_ch simply matches nothing and reads as not ready.
  always_comb begin
    cfg_ready = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (32'(cfg_ch) == i) cfg_ready = ~rst_n | ~pend_q[i];
    end
  end

  assign xfer = cfg_valid & cfg_ready;

  always_comb begin
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    pulse_d = '0;
    busy_d  = busy_q;
    div_d   = div_q;
    poff_d  = poff_q;
    mode_d  = mode_q;
    sdiv_d  = sdiv_q;
    spoff_d = spoff_q;
    smode_d = smode_q;
    pend_d  = pend_q;
    for (int i = 0; i < NCH; i++) begin
      if (!en[i]) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        busy_d[i] = 1'b0;
      end else begin
        if (running[i]) begin
          if (wrap[i]) begin
            cnt_d[i] = '0;
            clk_d[i] = ~clk_q[i];
          end else begin
            cnt_d[i]   = cnt_q[i] + 1'b1;
            pulse_d[i] = (cnt_q[i] == poff_q[i]) && (poff_q[i] < div_q[i]);
          end
        end
        // One-shot: busy on an en rise, held until the wrap. Continuous: busy
        // simply follows en one cycle later.
        if (mode_q[i]) busy_d[i] = rise[i] | (busy_q[i] & ~wrap[i]);
        else           busy_d[i] = 1'b1;
      end
      // Shadow-to-active swap only at period boundaries or while idle. A
      // transfer in this same cycle cannot collide with this swap, because a
      // transfer needs pending to be clear.
      if (pend_q[i] && (wrap[i] || !busy_q[i])) begin
        div_d[i]  = sdiv_q[i];
        poff_d[i] = spoff_q[i];
        mode_d[i] = smode_q[i];
        pend_d[i] = 1'b0;
      end
      if (xfer && (32'(cfg_ch) == i)) begin
        sdiv_d[i]  = cfg_div;
        spoff_d[i] = cfg_pulse;
        smode_d[i] = cfg_mode;
        pend_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]   <= '0;
        div_q[i]   <= DIV_RST;
        poff_q[i]  <= POFF_RST;
        sdiv_q[i]  <= DIV_RST;
        spoff_q[i] <= POFF_RST;
      end
      mode_q  <= '0;
      smode_q <= '0;
      pend_q  <= '0;
      clk_q   <= '0;
      pulse_q <= '0;
      busy_q  <= '0;
      en_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      poff_q  <= poff_d;
      sdiv_q  <= sdiv_d;
      spoff_q <= spoff_d;
      mode_q  <= mode_d;
      smode_q <= smode_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
    end
  end

  assign clk_out = clk_q;
  assign pulse   = pulse_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi with NCH=2, CNT_W=8, DEF_DIV=4, DEF_PULSE=2.
// Output activity is reduced to timestamped events:
//   busy change, clk_out change, or a cycle with pulse high.
// Each event is packed as {cycle, channel, kind, value}.
// The stimulus pushes the events it expects into exp_q, kept sorted by that
// key. A monitor process pops the front of exp_q for every event it observes.
module tb_clk_div_multi;

  localparam int W = 36;
  localparam int K_BUSY = 0, K_CLK = 1, K_PULSE = 2;

  logic       clk50, rst_n, cfg_valid, cfg_ready, cfg_mode;
  logic [1:0] en, clk_out, pulse, busy;
  logic [0:0] cfg_ch;
  logic [7:0] cfg_div, cfg_pulse;

  logic [W-1:0] exp_q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 0;

  clk_div_multi #(.NCH(2), .CNT_W(8), .DEF_DIV(4), .DEF_PULSE(2)) dut (
    .clk50(clk50), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_pulse(cfg_pulse), .cfg_mode(cfg_mode), .clk_out(clk_out),
    .pulse(pulse), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk50 = 1'b0;
    forever #5 clk50 = ~clk50;
  end

  always @(posedge clk50) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic push_ev(input int c, input int ch, input int kind, input bit v);
    logic [W-1:0] e;
    int pos;
    e = {32'(c), 1'(ch), 2'(kind), v};
    pos = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i] > e) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, e);
  endtask

  task automatic push_clk(input int ch, input int first, input int step, input int n, input bit v0);
    for (int k = 0; k < n; k++) push_ev(first + k * step, ch, K_CLK, v0 ^ k[0]);
  endtask

  task automatic push_pulse(input int ch, input int first, input int step, input int n);
    for (int k = 0; k < n; k++) push_ev(first + k * step, ch, K_PULSE, 1'b1);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk50);
  endtask

  task automatic chk_ready(input int ch, input bit expv, input string name);
    cfg_ch = 1'(ch);
    #1;
    n_cmp++;
    if (cfg_ready !== expv) begin
      n_bad++;
      $display("FAIL %s: cfg_ready=%0b expected %0b (cycle %0d)", name, cfg_ready, expv, cyc);
    end
  endtask

  // Drive one request at the current negedge. Control returns at the negedge
  // after the edge that samples it, with cfg_valid already dropped.
  task automatic do_cfg(input int ch, input int dv, input int pv, input bit md, input string name);
    cfg_ch = 1'(ch);
    cfg_div = 8'(dv);
    cfg_pulse = 8'(pv);
    cfg_mode = md;
    cfg_valid = 1'b1;
    chk_ready(ch, 1'b1, name);
    @(negedge clk50);
    cfg_valid = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check_event(input logic [W-1:0] act);
    logic [W-1:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: cyc=%0d ch=%0d kind=%0d val=%0b, none expected",
               act[W-1:4], act[3], act[2:1], act[0]);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        n_bad++;
        $display("FAIL event: got cyc=%0d ch=%0d kind=%0d val=%0b, expected cyc=%0d ch=%0d kind=%0d val=%0b",
                 act[W-1:4], act[3], act[2:1], act[0], e[W-1:4], e[3], e[2:1], e[0]);
      end
    end
  endtask

  initial begin
    logic [1:0] prev_clk, prev_busy;
    forever begin
      @(negedge clk50);
      if (mon_en) begin
        for (int ch = 0; ch < 2; ch++) begin
          if (busy[ch] !== prev_busy[ch]) check_event({32'(cyc), 1'(ch), 2'(K_BUSY), busy[ch]});
          if (clk_out[ch] !== prev_clk[ch]) check_event({32'(cyc), 1'(ch), 2'(K_CLK), clk_out[ch]});
          if (pulse[ch] !== 1'b0) check_event({32'(cyc), 1'(ch), 2'(K_PULSE), pulse[ch]});
        end
      end
      prev_clk = clk_out;
      prev_busy = busy;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int a0, b, r, c, s;
    rst_n = 1'b0;
    en = 2'b00;
    cfg_valid = 1'b0;
    cfg_ch = 1'b0;
    cfg_div = 8'd0;
    cfg_pulse = 8'd0;
    cfg_mode = 1'b0;
    repeat (3) @(negedge clk50);

    // Reset state
    n_cmp++; if (clk_out !== 2'b00) begin n_bad++; $display("FAIL rst_clk_out: %b expected 00", clk_out); end
    n_cmp++; if (pulse !== 2'b00) begin n_bad++; $display("FAIL rst_pulse: %b expected 00", pulse); end
    n_cmp++; if (busy !== 2'b00) begin n_bad++; $display("FAIL rst_busy: %b expected 00", busy); end
    chk_ready(0, 1'b1, "rst_ready_ch0");
    chk_ready(1, 1'b1, "rst_ready_ch1");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Default divider on ch0: toggle every 5, pulse 3 cycles after count start.
    // Then a mid-count config change to div=1 pulse=0.
    a0 = cyc + 2;
    push_ev(a0, 0, K_BUSY, 1'b1);
    push_clk(0, a0 + 5, 5, 3, 1'b1);
    push_pulse(0, a0 + 3, 5, 3);
    push_clk(0, a0 + 17, 2, 3, 1'b0);
    push_pulse(0, a0 + 16, 2, 4);
    push_ev(a0 + 23, 0, K_BUSY, 1'b0);
    wait_until(a0 - 1);
    en = 2'b01;
    wait_until(a0 + 11);
    do_cfg(0, 1, 0, 1'b0, "mid_ready");
    chk_ready(0, 1'b0, "mid_pending");
    wait_until(a0 + 14);
    chk_ready(0, 1'b0, "mid_pending_at_wrap");
    wait_until(a0 + 15);
    chk_ready(0, 1'b1, "mid_applied");
    wait_until(a0 + 22);
    en = 2'b00;

    // ch1 one-shot div=3 pulse=1, run twice with an en low/high between
    b = a0 + 25;
    r = b + 2;
    push_ev(r, 1, K_BUSY, 1'b1);
    push_pulse(1, r + 2, 1, 1);
    push_ev(r + 4, 1, K_CLK, 1'b1);
    push_ev(r + 4, 1, K_BUSY, 1'b0);
    push_ev(r + 8, 1, K_CLK, 1'b0);
    push_ev(r + 10, 1, K_BUSY, 1'b1);
    push_pulse(1, r + 12, 1, 1);
    push_ev(r + 14, 1, K_CLK, 1'b1);
    push_ev(r + 14, 1, K_BUSY, 1'b0);
    wait_until(b - 1);
    do_cfg(1, 3, 1, 1'b1, "os_ready");
    chk_ready(1, 1'b0, "os_pending");
    @(negedge clk50);
    chk_ready(1, 1'b1, "os_applied_idle");
    en = 2'b10;
    wait_until(r + 7);
    en = 2'b00;
    wait_until(r + 9);
    en = 2'b10;
    wait_until(r + 18);

    // ch0 pulse_off == div: no pulses. Then div=0, then transfers on wrap edges.
    c = r + 19;
    s = c + 2;
    push_ev(s, 0, K_BUSY, 1'b1);
    push_clk(0, s + 5, 5, 4, 1'b1);
    push_clk(0, s + 21, 1, 6, 1'b1);
    push_clk(0, s + 29, 3, 3, 1'b1);
    push_clk(0, s + 37, 2, 2, 1'b0);
    push_pulse(0, s + 36, 2, 3);
    wait_until(c - 1);
    do_cfg(0, 4, 4, 1'b0, "nopulse_ready");
    @(negedge clk50);
    chk_ready(0, 1'b1, "nopulse_applied");
    en = 2'b11;
    wait_until(s + 16);
    do_cfg(0, 0, 0, 1'b0, "div0_ready");
    chk_ready(0, 1'b0, "div0_pending");
    wait_until(s + 20);
    chk_ready(0, 1'b1, "div0_applied");
    wait_until(s + 24);
    do_cfg(0, 2, 5, 1'b0, "wrap1_ready");
    chk_ready(0, 1'b0, "wrap1_pending");
    @(negedge clk50);
    chk_ready(0, 1'b1, "wrap1_applied");
    wait_until(s + 31);
    do_cfg(0, 1, 0, 1'b0, "wrap2_ready");
    chk_ready(0, 1'b0, "wrap2_pending");
    wait_until(s + 34);
    chk_ready(0, 1'b0, "wrap2_still_pending");
    wait_until(s + 35);
    chk_ready(0, 1'b1, "wrap2_applied");

    // One-cycle reset mid-run with a pending config, then defaults on both channels
    wait_until(s + 39);
    do_cfg(0, 3, 1, 1'b0, "prerst_ready");
    chk_ready(0, 1'b0, "prerst_pending");
    push_ev(s + 41, 0, K_BUSY, 1'b0);
    push_ev(s + 41, 0, K_CLK, 1'b0);
    push_ev(s + 41, 1, K_CLK, 1'b0);
    for (int ch = 0; ch < 2; ch++) begin
      push_ev(s + 42, ch, K_BUSY, 1'b1);
      push_pulse(ch, s + 45, 5, 2);
      push_clk(ch, s + 47, 5, 2, 1'b1);
      push_ev(s + 54, ch, K_BUSY, 1'b0);
    end
    rst_n = 1'b0;
    @(negedge clk50);
    chk_ready(0, 1'b1, "inrst_ready");
    rst_n = 1'b1;
    @(negedge clk50);
    chk_ready(0, 1'b1, "postrst_ready");
    wait_until(s + 53);
    en = 2'b00;
    wait_until(s + 62);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events: %0d expected events never seen, first cyc=%0d ch=%0d kind=%0d",
               exp_q.size(), exp_q[0][W-1:4], exp_q[0][3], exp_q[0][2:1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
